// File: rtl/spr_commit_pkg.sv
// Shared types for the SPR commit stage: data words, register-move kinds,
// the buffered entry layout and the destination decode helpers.
package Pu_types;

  typedef logic [31:0] Word;
  typedef logic [31:0] Condition_register;
  typedef logic [31:0] Msr;

  typedef enum logic [3:0] {
    Rmv_none = 4'd0,
    Rmv_gtc  = 4'd1,
    Rmv_ctc  = 4'd2,
    Rmv_ctg  = 4'd3,
    Rmv_stg  = 4'd4,
    Rmv_mtg  = 4'd5,
    Rmv_gts  = 4'd6,
    Rmv_gtm  = 4'd7
  } Register_move;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HELD  = 2'd1,
    STALL = 2'd2
  } Spr_commit_state;

  // Wide enough for any supported SPR_AW; narrower selects are zero-extended.
  localparam int SPR_SEL_W = 8;

  typedef struct packed {
    Register_move           reg_mv;
    logic [4:0]             gpr_dest;
    logic [SPR_SEL_W-1:0]   spr_sel;
    Word                    res;
    Condition_register      cr;
    Msr                     msr;
  } Spr_commit_entry;

  function automatic logic mv_needs_gpr(input Register_move mv);
    case (mv)
      Rmv_none, Rmv_ctg, Rmv_stg, Rmv_mtg: mv_needs_gpr = 1'b1;
      default:                             mv_needs_gpr = 1'b0;
    endcase
  endfunction

  function automatic logic mv_writes_cr(input Register_move mv);
    case (mv)
      Rmv_none, Rmv_gtc, Rmv_ctc: mv_writes_cr = 1'b1;
      default:                    mv_writes_cr = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/spr_commit_if.sv
// Result handshake from the SPR execution unit into the commit stage.
interface spr_commit_if
  import Pu_types::*;
#(
  parameter int SPR_AW = 3
);
  logic              in_valid;
  logic              in_ready;
  Register_move      in_reg_mv;
  logic [4:0]        in_gpr_dest;
  logic [SPR_AW-1:0] in_spr_sel;
  Word               in_res;
  Condition_register in_cr;
  Msr                in_msr;

  modport master (
    output in_valid, in_reg_mv, in_gpr_dest, in_spr_sel, in_res, in_cr, in_msr,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_reg_mv, in_gpr_dest, in_spr_sel, in_res, in_cr, in_msr,
    output in_ready
  );
endinterface

// File: rtl/spr_commit_spr_file.sv
// Small SPR register array: one write port, one combinational read port,
// cleared in full by the synchronous active-low reset.
module spr_file
  import Pu_types::*;
#(
  parameter int NUM_SPR = 8,
  parameter int SPR_AW  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [SPR_AW-1:0] waddr,
  input  Word               wdata,
  input  logic [SPR_AW-1:0] raddr,
  output Word               rdata
);

  Word                regs [NUM_SPR];
  logic [NUM_SPR-1:0] hit;

  generate
    for (genvar gi = 0; gi < NUM_SPR; gi++) begin : g_hit
      assign hit[gi] = we && (waddr == SPR_AW'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SPR; i++) begin
      if (!reset) begin
        regs[i] <= '0;
      end else if (hit[i]) begin
        regs[i] <= wdata;
      end
    end
  end

  assign rdata = regs[raddr];

endmodule

// File: rtl/spr_commit.sv
// One-entry commit buffer behind the SPR execution unit; owns CR, MSR and the
// SPR file and forwards the pending entry back onto the operand outputs.
module spr_commit
  import Pu_types::*;
#(
  parameter int NUM_SPR = 8,
  parameter int SPR_AW  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  spr_commit_if.slave       res_bus,
  output logic              gpr_we,
  input  logic              gpr_ready,
  output logic [4:0]        gpr_waddr,
  output Word               gpr_wdata,
  input  logic [SPR_AW-1:0] rd_spr_sel,
  output Word               spr_rd,
  output Condition_register cr,
  output Msr                msr,
  output logic              pending,
  output logic [31:0]       retired
);

  logic              occ_reg, occ_next;
  Spr_commit_entry   entry_reg, entry_next;
  Condition_register cr_reg, cr_next;
  Msr                msr_reg, msr_next;
  logic [31:0]       retired_reg, retired_next;

  Spr_commit_state   state;
  logic              needs_gpr, writes_cr, writes_msr, writes_spr;
  logic              retire, commit, ready, accept, fwd, spr_we;
  Word               arch_spr;

  always_ff @(posedge clk) begin
    if (!reset) begin
      occ_reg     <= 1'b0;
      entry_reg   <= '0;
      cr_reg      <= '0;
      msr_reg     <= '0;
      retired_reg <= '0;
    end else begin
      occ_reg     <= occ_next;
      entry_reg   <= entry_next;
      cr_reg      <= cr_next;
      msr_reg     <= msr_next;
      retired_reg <= retired_next;
    end
  end

  always_comb begin
    needs_gpr  = mv_needs_gpr(entry_reg.reg_mv);
    writes_cr  = mv_writes_cr(entry_reg.reg_mv);
    writes_msr = (entry_reg.reg_mv == Rmv_gtm);
    writes_spr = (entry_reg.reg_mv == Rmv_gts);

    state = EMPTY;
    if (occ_reg) begin
      state = (needs_gpr && !gpr_ready) ? STALL : HELD;
    end

    // Flush suppresses the commit side effects but still frees the slot.
    retire = (state == HELD);
    commit = retire && !flush;
    ready  = !flush && (state != STALL);
    accept = res_bus.in_valid && ready;

    occ_next = accept || ((state == STALL) && !flush);

    entry_next = entry_reg;
    if (accept) begin
      entry_next.reg_mv   = res_bus.in_reg_mv;
      entry_next.gpr_dest = res_bus.in_gpr_dest;
      entry_next.spr_sel  = SPR_SEL_W'(res_bus.in_spr_sel);
      entry_next.res      = res_bus.in_res;
      entry_next.cr       = res_bus.in_cr;
      entry_next.msr      = res_bus.in_msr;
    end

    cr_next      = (commit && writes_cr)  ? entry_reg.cr  : cr_reg;
    msr_next     = (commit && writes_msr) ? entry_reg.msr : msr_reg;
    spr_we       = commit && writes_spr;
    retired_next = retired_reg + {31'd0, commit};
  end

  spr_file #(
    .NUM_SPR (NUM_SPR),
    .SPR_AW  (SPR_AW)
  ) u_spr_file (
    .clk   (clk),
    .reset (reset),
    .we    (spr_we),
    .waddr (entry_reg.spr_sel[SPR_AW-1:0]),
    .wdata (entry_reg.res),
    .raddr (rd_spr_sel),
    .rdata (arch_spr)
  );

  assign res_bus.in_ready = ready;

  assign gpr_we    = occ_reg && needs_gpr && !flush;
  assign gpr_waddr = entry_reg.gpr_dest;
  assign gpr_wdata = entry_reg.res;

  assign fwd     = occ_reg && !flush;
  assign cr      = (fwd && writes_cr)  ? entry_reg.cr  : cr_reg;
  assign msr     = (fwd && writes_msr) ? entry_reg.msr : msr_reg;
  assign spr_rd  = (fwd && writes_spr && (entry_reg.spr_sel == SPR_SEL_W'(rd_spr_sel)))
                   ? entry_reg.res : arch_spr;
  assign pending = occ_reg;
  assign retired = retired_reg;

endmodule

// File: tb/tb_spr_commit.sv
// Directed bench for spr_commit: a per-cycle vector table followed by
// hand-written stall, flush and reset sequences.
module tb_spr_commit;
  import Pu_types::*;

  logic              clk;
  logic              reset;
  logic              flush;
  logic              gpr_we;
  logic              gpr_ready;
  logic [4:0]        gpr_waddr;
  Word               gpr_wdata;
  logic [2:0]        rd_spr_sel;
  Word               spr_rd;
  Condition_register cr;
  Msr                msr;
  logic              pending;
  logic [31:0]       retired;

  int total = 0;
  int bad   = 0;

  spr_commit_if #(.SPR_AW(3)) bus ();

  spr_commit #(.NUM_SPR(8), .SPR_AW(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .res_bus    (bus.slave),
    .gpr_we     (gpr_we),
    .gpr_ready  (gpr_ready),
    .gpr_waddr  (gpr_waddr),
    .gpr_wdata  (gpr_wdata),
    .rd_spr_sel (rd_spr_sel),
    .spr_rd     (spr_rd),
    .cr         (cr),
    .msr        (msr),
    .pending    (pending),
    .retired    (retired)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic         flush;
    logic         valid;
    Register_move mv;
    logic [4:0]   dest;
    logic [2:0]   sel;
    logic [31:0]  res;
    logic [31:0]  crv;
    logic [31:0]  msrv;
    logic         gready;
    logic [2:0]   rd;
    logic         e_ready;
    logic         e_we;
    logic [4:0]   e_waddr;
    logic [31:0]  e_wdata;
    logic [31:0]  e_spr;
    logic [31:0]  e_cr;
    logic [31:0]  e_msr;
    logic         e_pending;
    logic [31:0]  e_retired;
  } vec_t;

  localparam int NV = 16;
  vec_t tbl [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input Register_move mv, input logic [4:0] dest,
                       input logic [2:0] sel, input logic [31:0] res,
                       input logic [31:0] crv, input logic [31:0] msrv);
    bus.in_valid    = v;
    bus.in_reg_mv   = mv;
    bus.in_gpr_dest = dest;
    bus.in_spr_sel  = sel;
    bus.in_res      = res;
    bus.in_cr       = crv;
    bus.in_msr      = msrv;
  endtask

  initial begin
    Register_move odd_mv;
    logic [3:0]   odd_bits;
    odd_bits = 4'hF;
    odd_mv   = Register_move'(odd_bits);

    //          flush valid mv       dest sel res            crv            msrv      grdy rd   rdy we wa wdata  spr            cr             msr      pend ret
    tbl[0]  = '{0, 0, Rmv_none, 0, 0, 32'h0,         32'h0,         32'h0,    1, 3,  1, 0, 0, 32'h0,  32'h0,         32'h0,         32'h0,    0, 0};
    tbl[1]  = '{0, 1, Rmv_gts,  0, 3, 32'hDEADBEEF,  32'h0,         32'h0,    1, 3,  1, 0, 0, 32'h0,  32'h0,         32'h0,         32'h0,    0, 0};
    tbl[2]  = '{0, 0, Rmv_none, 0, 0, 32'h0,         32'h0,         32'h0,    1, 3,  1, 0, 0, 32'h0,  32'hDEADBEEF,  32'h0,         32'h0,    1, 0};
    tbl[3]  = '{0, 0, Rmv_none, 0, 0, 32'h0,         32'h0,         32'h0,    1, 3,  1, 0, 0, 32'h0,  32'hDEADBEEF,  32'h0,         32'h0,    0, 1};
    tbl[4]  = '{0, 1, Rmv_gtc,  0, 0, 32'h0,         32'h12345678,  32'h0,    1, 3,  1, 0, 0, 32'h0,  32'hDEADBEEF,  32'h0,         32'h0,    0, 1};
    tbl[5]  = '{0, 1, Rmv_gtm,  0, 0, 32'h0,         32'h0,         32'h8000, 1, 3,  1, 0, 0, 32'h0,  32'hDEADBEEF,  32'h12345678,  32'h0,    1, 1};
    tbl[6]  = '{0, 0, Rmv_none, 0, 0, 32'h0,         32'h0,         32'h0,    1, 3,  1, 0, 0, 32'h0,  32'hDEADBEEF,  32'h12345678,  32'h8000, 1, 2};
    tbl[7]  = '{0, 0, Rmv_none, 0, 0, 32'h0,         32'h0,         32'h0,    1, 3,  1, 0, 0, 32'h0,  32'hDEADBEEF,  32'h12345678,  32'h8000, 0, 3};
    tbl[8]  = '{0, 1, Rmv_none, 9, 0, 32'hA5,        32'hCAFE,      32'h0,    1, 3,  1, 0, 0, 32'h0,  32'hDEADBEEF,  32'h12345678,  32'h8000, 0, 3};
    tbl[9]  = '{0, 0, Rmv_none, 0, 0, 32'h0,         32'h0,         32'h0,    1, 3,  1, 1, 9, 32'hA5, 32'hDEADBEEF,  32'hCAFE,      32'h8000, 1, 3};
    tbl[10] = '{0, 1, odd_mv,   1, 0, 32'h1,         32'h1111,      32'h2222, 1, 3,  1, 0, 0, 32'h0,  32'hDEADBEEF,  32'hCAFE,      32'h8000, 0, 4};
    tbl[11] = '{0, 0, Rmv_none, 0, 0, 32'h0,         32'h0,         32'h0,    1, 3,  1, 0, 0, 32'h0,  32'hDEADBEEF,  32'hCAFE,      32'h8000, 1, 4};
    tbl[12] = '{0, 0, Rmv_none, 0, 0, 32'h0,         32'h0,         32'h0,    1, 3,  1, 0, 0, 32'h0,  32'hDEADBEEF,  32'hCAFE,      32'h8000, 0, 5};
    tbl[13] = '{0, 1, Rmv_gts,  0, 5, 32'h55,        32'h0,         32'h0,    1, 3,  1, 0, 0, 32'h0,  32'hDEADBEEF,  32'hCAFE,      32'h8000, 0, 5};
    tbl[14] = '{0, 0, Rmv_none, 0, 0, 32'h0,         32'h0,         32'h0,    1, 3,  1, 0, 0, 32'h0,  32'hDEADBEEF,  32'hCAFE,      32'h8000, 1, 5};
    tbl[15] = '{0, 0, Rmv_none, 0, 0, 32'h0,         32'h0,         32'h0,    1, 5,  1, 0, 0, 32'h0,  32'h55,        32'hCAFE,      32'h8000, 0, 6};

    // Reset held across two edges with a valid result on the bus.
    reset = 1'b0; flush = 1'b0; gpr_ready = 1'b1; rd_spr_sel = 3'd3;
    drive(1'b1, Rmv_gts, 5'd0, 3'd3, 32'h1234, 32'hFFFF, 32'hFFFF);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, Rmv_none, 5'd0, 3'd0, 32'h0, 32'h0, 32'h0);
    #1;
    chk("rst cr", cr, 32'h0);
    chk("rst msr", msr, 32'h0);
    chk("rst spr_rd", spr_rd, 32'h0);
    chk("rst retired", retired, 32'h0);
    chk("rst pending", {31'd0, pending}, 32'd0);
    chk("rst gpr_we", {31'd0, gpr_we}, 32'd0);
    chk("rst in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      flush      = tbl[i].flush;
      gpr_ready  = tbl[i].gready;
      rd_spr_sel = tbl[i].rd;
      drive(tbl[i].valid, tbl[i].mv, tbl[i].dest, tbl[i].sel, tbl[i].res, tbl[i].crv, tbl[i].msrv);
      #1;
      chk($sformatf("v%0d in_ready", i), {31'd0, bus.in_ready}, {31'd0, tbl[i].e_ready});
      chk($sformatf("v%0d gpr_we", i), {31'd0, gpr_we}, {31'd0, tbl[i].e_we});
      if (tbl[i].e_we) begin
        chk($sformatf("v%0d gpr_waddr", i), {27'd0, gpr_waddr}, {27'd0, tbl[i].e_waddr});
        chk($sformatf("v%0d gpr_wdata", i), gpr_wdata, tbl[i].e_wdata);
      end
      chk($sformatf("v%0d spr_rd", i), spr_rd, tbl[i].e_spr);
      chk($sformatf("v%0d cr", i), cr, tbl[i].e_cr);
      chk($sformatf("v%0d msr", i), msr, tbl[i].e_msr);
      chk($sformatf("v%0d pending", i), {31'd0, pending}, {31'd0, tbl[i].e_pending});
      chk($sformatf("v%0d retired", i), retired, tbl[i].e_retired);
      @(negedge clk);
    end

    // GPR-bound move stalled for three cycles, then released.
    gpr_ready = 1'b0;
    drive(1'b1, Rmv_ctg, 5'd7, 3'd0, 32'h77, 32'h0, 32'h0);
    @(negedge clk);
    drive(1'b0, Rmv_none, 5'd0, 3'd0, 32'h0, 32'h0, 32'h0);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("stall%0d gpr_we", c), {31'd0, gpr_we}, 32'd1);
      chk($sformatf("stall%0d gpr_waddr", c), {27'd0, gpr_waddr}, 32'd7);
      chk($sformatf("stall%0d gpr_wdata", c), gpr_wdata, 32'h77);
      chk($sformatf("stall%0d in_ready", c), {31'd0, bus.in_ready}, 32'd0);
      @(negedge clk);
    end
    gpr_ready = 1'b1;
    #1;
    chk("stall3 gpr_we", {31'd0, gpr_we}, 32'd1);
    chk("stall3 gpr_waddr", {27'd0, gpr_waddr}, 32'd7);
    chk("stall3 in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("stall3 retired", retired, 32'd6);
    @(negedge clk);
    #1;
    chk("stall done pending", {31'd0, pending}, 32'd0);
    chk("stall done retired", retired, 32'd7);
    @(negedge clk);

    // Flush a stalled Rmv_none entry; a valid input during the flush is refused.
    gpr_ready = 1'b0;
    drive(1'b1, Rmv_none, 5'd4, 3'd0, 32'h44, 32'hBBBB, 32'h0);
    @(negedge clk);
    drive(1'b0, Rmv_none, 5'd0, 3'd0, 32'h0, 32'h0, 32'h0);
    #1;
    chk("flush pre gpr_we", {31'd0, gpr_we}, 32'd1);
    chk("flush pre cr fwd", cr, 32'hBBBB);
    flush = 1'b1;
    drive(1'b1, Rmv_gtc, 5'd0, 3'd0, 32'h0, 32'h9999, 32'h0);
    #1;
    chk("flush gpr_we", {31'd0, gpr_we}, 32'd0);
    chk("flush in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("flush cr", cr, 32'hCAFE);
    @(negedge clk);
    flush = 1'b0; gpr_ready = 1'b1;
    drive(1'b0, Rmv_none, 5'd0, 3'd0, 32'h0, 32'h0, 32'h0);
    #1;
    chk("flush post pending", {31'd0, pending}, 32'd0);
    chk("flush post cr", cr, 32'hCAFE);
    chk("flush post retired", retired, 32'd7);
    @(negedge clk);

    // SPR5 written, then a later GPR entry is lost to reset mid-stall.
    rd_spr_sel = 3'd5;
    drive(1'b1, Rmv_gts, 5'd0, 3'd5, 32'h5A5A, 32'h0, 32'h0);
    @(negedge clk);
    drive(1'b0, Rmv_none, 5'd0, 3'd0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    #1;
    chk("pre-rst spr5", spr_rd, 32'h5A5A);
    chk("pre-rst retired", retired, 32'd8);
    gpr_ready = 1'b0;
    drive(1'b1, Rmv_ctg, 5'd2, 3'd0, 32'h22, 32'h0, 32'h0);
    @(negedge clk);
    drive(1'b0, Rmv_none, 5'd0, 3'd0, 32'h0, 32'h0, 32'h0);
    #1;
    chk("mid-stall gpr_we", {31'd0, gpr_we}, 32'd1);
    reset = 1'b0;
    drive(1'b1, Rmv_gts, 5'd0, 3'd5, 32'hEEEE, 32'h0, 32'h0);
    @(negedge clk);
    reset = 1'b1; gpr_ready = 1'b1;
    drive(1'b0, Rmv_none, 5'd0, 3'd0, 32'h0, 32'h0, 32'h0);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("post-rst%0d gpr_we", c), {31'd0, gpr_we}, 32'd0);
      chk($sformatf("post-rst%0d pending", c), {31'd0, pending}, 32'd0);
      chk($sformatf("post-rst%0d spr5", c), spr_rd, 32'h0);
      chk($sformatf("post-rst%0d retired", c), retired, 32'd0);
      @(negedge clk);
    end
    #1;
    chk("post-rst cr", cr, 32'h0);
    chk("post-rst msr", msr, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
